apb_protocol_sys: RTL and testbench
===================================

Name: apb_protocol_sys

Overview:
Self-contained APB subsystem. One APB master FSM drives two internal 8-bit memory slaves over an internal APB bus (PSEL1/PSEL2, PENABLE, PWRITE, PADDR, PWDATA, PRDATA, PREADY). The user side issues byte reads and writes through simple request ports. Address bit 8 selects the slave. The block is used as a standalone APB verification target.

Parameters:
- ADDR_WIDTH, 9, user address width; MSB is the slave select, the low 8 bits are the slave offset.
- DATA_WIDTH, 8, data width.
- MEM_DEPTH, 64, bytes per slave; offsets >= MEM_DEPTH are errors.

Ports:
- PCLK  in  1  system clock; all state changes on the rising edge.
- PRESETn  in  1  asynchronous, active-high reset (asserted when 1, despite the name).
- transfer  in  1  request; while 1, the master issues back-to-back transfers.
- READ_WRITE  in  1  direction: 0 = write, 1 = read.
- apb_write_paddr  in  9  write address; bit 8 = slave (0 = slave1, 1 = slave2), bits 7:0 = offset.
- apb_write_data  in  8  write data.
- apb_read_paddr  in  9  read address, same encoding as the write address.
- PSLVERR  out  1  slave error flag for the current ACCESS cycle.
- apb_read_data_out  out  8  last successfully read byte.

Behaviour:
- Master FSM states:
  - IDLE: PSEL1 = PSEL2 = 0, PENABLE = 0. If transfer = 1, go to SETUP; otherwise stay in IDLE.
  - SETUP: one PSEL asserted, PENABLE = 0. Always goes to ACCESS on the next edge.
  - ACCESS: PENABLE = 1. Slaves are always ready (PREADY = 1), so no wait states and ACCESS lasts exactly one cycle. Next state is SETUP if transfer = 1, otherwise IDLE.
  - One transfer therefore takes 2 cycles when back-to-back.
- Capture: on the edge that enters SETUP, the master registers PWRITE = ~READ_WRITE and PADDR. PADDR comes from apb_write_paddr when writing and from apb_read_paddr when reading.
  - For writes, PWDATA = apb_write_data is captured on the same edge.
  - Captured values are held stable through SETUP and ACCESS.
  - Input changes during SETUP or ACCESS do not affect the transfer in flight.
- Decode: PADDR[8] = 0 selects slave1 (PSEL1); PADDR[8] = 1 selects slave2 (PSEL2). The offset is PADDR[7:0].
- Write: when a slave is selected, in ACCESS, with PWRITE = 1 and offset < MEM_DEPTH, mem[offset] <= PWDATA on the rising edge that ends ACCESS.
- Read:
  - The slave drives PRDATA = mem[offset] combinationally while selected.
  - At the edge ending a read ACCESS with no error, apb_read_data_out <= PRDATA.
  - apb_read_data_out is held until the next successful read.
  - Read latency: the data is visible 2 edges after the SETUP-entry edge.
- Errors:
  - An offset >= MEM_DEPTH (offset bits 7:6 nonzero) is an error.
  - PSLVERR = 1 combinationally for the whole ACCESS cycle of an erroring transfer, and 0 at all other times.
  - On an erroring write, the memory is not modified. On an erroring read, apb_read_data_out is not updated.
- Reset (PRESETn = 1):
  - Immediately forces the FSM to IDLE, all PSELs and PENABLE to 0, PSLVERR to 0, and apb_read_data_out to 0x00.
  - A transfer in progress is aborted; a write aborted before its ACCESS edge does not commit.
  - Memory contents are NOT reset and are retained across reset. Unwritten locations are undefined.
- transfer deasserted while in SETUP: the transfer still completes through ACCESS, then the FSM goes to IDLE.
- Address width: 9-bit inputs; any wider value presented by the bench is truncated, e.g. 526 becomes 14 (slave1, offset 14).

Test Plan:
- Reset, then transfer = 1 with READ_WRITE = 0. Write slave1 offsets 0..7 with data 2*i, then slave2 (address 256+i) with data i. Pulse reset, set READ_WRITE = 1, read both ranges -> apb_read_data_out = 0,2,..,14 for slave1, then 0..7 for slave2; PSLVERR stays 0.
- Write address 14 (slave1) with data 9 and address 22 with data 35, then read 14 and 22 -> 0x09 and 0x23.
- Write to address 0x050 (offset 80) -> PSLVERR = 1 during ACCESS only, memory unchanged. Read of 0x050 -> PSLVERR = 1, apb_read_data_out keeps its previous value.
- Hold transfer = 1 -> FSM cycles IDLE, SETUP, ACCESS, SETUP, ACCESS...; PENABLE is high every other cycle. Drop transfer in SETUP -> the transfer completes, then IDLE.
- Assert PRESETn asynchronously during a write SETUP -> immediate IDLE, outputs 0, that location unchanged on a later read. Previously written data survives the reset.
- Change apb_write_data mid-ACCESS -> the stored value equals the data captured at SETUP entry.

Source files
------------

// File: rtl/apb_protocol_sys.sv
// APB subsystem: one master FSM driving two byte-wide memory slaves on an internal bus.
// User requests are captured on SETUP entry and held stable through ACCESS.
module apb_protocol_sys #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 64
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  transfer,
  input  logic                  READ_WRITE,
  input  logic [ADDR_WIDTH-1:0] apb_write_paddr,
  input  logic [DATA_WIDTH-1:0] apb_write_data,
  input  logic [ADDR_WIDTH-1:0] apb_read_paddr,
  output logic                  PSLVERR,
  output logic [DATA_WIDTH-1:0] apb_read_data_out
);

  localparam int unsigned OFFS_WIDTH = ADDR_WIDTH - 1;
  localparam int unsigned IDX_WIDTH  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned NUM_SLV    = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  typedef struct packed {
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
  } apb_req_t;

  state_e                state_q, state_d;
  apb_req_t              req_q, req_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Internal APB bus, decoded from the registered master state and request
  logic                  psel1_c;
  logic                  psel2_c;
  logic                  penable_c;
  logic                  slv_sel_c;
  logic [OFFS_WIDTH-1:0] offset_c;
  logic [IDX_WIDTH-1:0]  idx_c;
  logic                  range_err_c;
  logic [DATA_WIDTH-1:0] prdata_c;
  logic                  pready_c;
  logic                  pslverr_c;
  logic                  wr_en_c;

  logic [DATA_WIDTH-1:0] mem_q [NUM_SLV][MEM_DEPTH];

  // Master state and captured request
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      state_q <= IDLE;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE:    if (transfer) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = transfer ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase

    // Capture only on the edge that enters SETUP; later input changes are ignored
    if (state_d == SETUP) begin
      req_d.pwrite = ~READ_WRITE;
      req_d.paddr  = READ_WRITE ? apb_read_paddr : apb_write_paddr;
      if (!READ_WRITE) begin
        req_d.pwdata = apb_write_data;
      end
    end

    if ((state_q == ACCESS) && !req_q.pwrite && pready_c && !pslverr_c) begin
      rdata_d = prdata_c;
    end
  end

  assign slv_sel_c   = req_q.paddr[ADDR_WIDTH-1];
  assign offset_c    = req_q.paddr[OFFS_WIDTH-1:0];
  assign idx_c       = offset_c[IDX_WIDTH-1:0];
  assign range_err_c = 32'(offset_c) >= MEM_DEPTH;

  assign psel1_c   = (state_q != IDLE) && !slv_sel_c;
  assign psel2_c   = (state_q != IDLE) &&  slv_sel_c;
  assign penable_c = (state_q == ACCESS);

  // Slaves: zero wait states, error on out-of-range offset
  assign pready_c  = 1'b1;
  assign pslverr_c = penable_c && (psel1_c || psel2_c) && range_err_c;
  assign prdata_c  = ((psel1_c || psel2_c) && !range_err_c) ? mem_q[slv_sel_c][idx_c] : '0;
  assign wr_en_c   = penable_c && (psel1_c || psel2_c) && req_q.pwrite && !range_err_c;

  // Memory is deliberately outside the reset domain so contents survive reset
  always_ff @(posedge PCLK) begin
    if (wr_en_c) begin
      mem_q[slv_sel_c][idx_c] <= req_q.pwdata;
    end
  end

  assign PSLVERR           = pslverr_c;
  assign apb_read_data_out = rdata_q;

endmodule

// File: tb/tb_apb_protocol_sys.sv
// Scoreboard bench for apb_protocol_sys: stimulus pushes expected ACCESS results,
// a monitor pops them whenever the bus enters ACCESS.
module tb_apb_protocol_sys;

  logic       PCLK;
  logic       PRESETn;
  logic       transfer;
  logic       READ_WRITE;
  logic [8:0] apb_write_paddr;
  logic [7:0] apb_write_data;
  logic [8:0] apb_read_paddr;
  logic       PSLVERR;
  logic [7:0] apb_read_data_out;

  typedef struct {
    logic       err;
    logic [7:0] rdata;
  } exp_t;

  exp_t       sb_q[$];
  int         checks;
  int         failures;
  logic [7:0] rd_model;

  apb_protocol_sys dut (
    .PCLK              (PCLK),
    .PRESETn           (PRESETn),
    .transfer          (transfer),
    .READ_WRITE        (READ_WRITE),
    .apb_write_paddr   (apb_write_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_paddr    (apb_read_paddr),
    .PSLVERR           (PSLVERR),
    .apb_read_data_out (apb_read_data_out)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Disturb every user input so only the values captured at SETUP entry matter
  task automatic scramble();
    apb_write_paddr = apb_write_paddr ^ 9'h1A5;
    apb_read_paddr  = apb_read_paddr ^ 9'h0C3;
    apb_write_data  = apb_write_data ^ 8'hFF;
    READ_WRITE      = ~READ_WRITE;
  endtask

  // Called at a negedge just before the capturing edge (IDLE, or ACCESS with transfer held)
  task automatic xfer(input bit rd, input int addr, input logic [7:0] data,
                      input logic [7:0] exp_rd, input bit exp_err, input bit keep);
    exp_t it;
    READ_WRITE = rd;
    if (rd) begin
      apb_read_paddr  = 9'(addr);
      apb_write_paddr = 9'(addr) ^ 9'h155;
      apb_write_data  = 8'hC3;
    end else begin
      apb_write_paddr = 9'(addr);
      apb_read_paddr  = 9'(addr) ^ 9'h0AA;
      apb_write_data  = data;
    end
    transfer = 1'b1;
    it.err = exp_err;
    if (rd && !exp_err) rd_model = exp_rd;
    it.rdata = rd_model;
    sb_q.push_back(it);
    @(posedge PCLK); @(negedge PCLK);
    scramble();
    transfer = keep;
    @(posedge PCLK); @(negedge PCLK);
    scramble();
    if (!keep) begin
      @(posedge PCLK); @(negedge PCLK);
    end
  endtask

  task automatic wr(input int addr, input logic [7:0] d, input bit err, input bit keep);
    xfer(1'b0, addr, d, 8'h00, err, keep);
  endtask

  task automatic rd(input int addr, input logic [7:0] e, input bit err, input bit keep);
    xfer(1'b1, addr, 8'h00, e, err, keep);
  endtask

  // Assert reset asynchronously 2 time units after the current posedge
  task automatic reset_now(input string tag);
    #2 PRESETn = 1'b1;
    #1;
    chk({tag, "_rdata"}, 32'(apb_read_data_out), 32'h0);
    chk({tag, "_pslverr"}, 32'(PSLVERR), 32'h0);
    chk({tag, "_penable"}, 32'(dut.penable_c), 32'h0);
    chk({tag, "_psel"}, 32'({dut.psel1_c, dut.psel2_c}), 32'h0);
    rd_model = 8'h00;
    transfer = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b0;
  endtask

  // Scoreboard monitor
  initial begin
    exp_t       it;
    bit         pend;
    bit         prev_pen;
    logic [7:0] pend_exp;
    pend     = 1'b0;
    prev_pen = 1'b0;
    pend_exp = 8'h00;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        if (pend) begin
          chk("read_data_out", 32'(apb_read_data_out), 32'(pend_exp));
          pend = 1'b0;
        end
        if (dut.penable_c) begin
          chk("penable_alternates", 32'(prev_pen), 32'h0);
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_access actual=ACCESS required=no transfer at %0t", $time);
          end else begin
            it = sb_q.pop_front();
            chk("pslverr_access", 32'(PSLVERR), 32'(it.err));
            pend     = 1'b1;
            pend_exp = it.rdata;
          end
        end else begin
          chk("pslverr_outside_access", 32'(PSLVERR), 32'h0);
        end
        prev_pen = dut.penable_c;
      end else begin
        pend     = 1'b0;
        prev_pen = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks          = 0;
    failures        = 0;
    rd_model        = 8'h00;
    PRESETn         = 1'b1;
    transfer        = 1'b0;
    READ_WRITE      = 1'b0;
    apb_write_paddr = '0;
    apb_write_data  = '0;
    apb_read_paddr  = '0;
    repeat (2) @(negedge PCLK);
    chk("reset_rdata", 32'(apb_read_data_out), 32'h0);
    chk("reset_pslverr", 32'(PSLVERR), 32'h0);
    PRESETn = 1'b0;
    @(negedge PCLK);

    // Back-to-back writes to both slaves
    for (int i = 0; i < 8; i++) wr(i, 8'(2 * i), 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) wr(256 + i, 8'(i), 1'b0, i != 7);

    @(posedge PCLK);
    reset_now("pulse");

    for (int i = 0; i < 8; i++) rd(i, 8'(2 * i), 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) rd(256 + i, 8'(i), 1'b0, i != 7);

    // 526 truncates to 14 (slave1)
    wr(526, 8'h09, 1'b0, 1'b1);
    wr(22, 8'h23, 1'b0, 1'b1);
    rd(14, 8'h09, 1'b0, 1'b1);
    rd(22, 8'h23, 1'b0, 1'b0);

    // Out-of-range offsets: no write, no read update
    wr(16, 8'h5C, 1'b0, 1'b1);
    wr(12'h050, 8'hAA, 1'b1, 1'b1);
    rd(12'h050, 8'h00, 1'b1, 1'b1);
    rd(16, 8'h5C, 1'b0, 1'b1);
    rd(12'h150, 8'h00, 1'b1, 1'b1);
    wr(12'h1C0, 8'h11, 1'b1, 1'b0);
    wr(12'h13F, 8'h3C, 1'b0, 1'b1);
    wr(12'h040, 8'h99, 1'b1, 1'b1);
    rd(12'h13F, 8'h3C, 1'b0, 1'b1);
    rd(0, 8'h00, 1'b0, 1'b0);

    // Abort a write in SETUP
    READ_WRITE      = 1'b0;
    apb_write_paddr = 9'd3;
    apb_write_data  = 8'hEE;
    transfer        = 1'b1;
    @(posedge PCLK);
    reset_now("abort");
    rd(3, 8'h06, 1'b0, 1'b1);
    rd(257, 8'h01, 1'b0, 1'b1);
    rd(16, 8'h5C, 1'b0, 1'b1);
    rd(14, 8'h09, 1'b0, 1'b0);

    // Inputs are scrambled during SETUP and ACCESS of each transfer
    wr(12'h105, 8'h77, 1'b0, 1'b0);
    rd(12'h105, 8'h77, 1'b0, 1'b0);
    rd(12'h140, 8'h00, 1'b1, 1'b0);

    repeat (4) @(negedge PCLK);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
